perf_stat_sequencer: RTL and testbench

//  Selects one of the five pipeline performance counters (total cycles, conditional and unconditional branches,

---
 rtl/perf_stat_pkg.sv | 54 +++++
 rtl/perf_stat_sequencer_if.sv | 32 +++
 rtl/perf_stat_sequencer_seg7_scan.sv | 50 +++++
 rtl/perf_stat_sequencer.sv | 163 ++++++++++++++++
 tb/tb_perf_stat_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_stat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | perf_stat_pkg                                                              |
// | FSM states, display-index constants and hex glyph helpers shared by the    |
// | performance-statistics display sequencer.                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package perf_stat_pkg;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    SNAP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] IDX_TOTAL  = 3'd0;
  localparam logic [2:0] IDX_COND   = 3'd1;
  localparam logic [2:0] IDX_UNCOND = 3'd2;
  localparam logic [2:0] IDX_SUCC   = 3'd3;
  localparam logic [2:0] IDX_LU     = 3'd4;
  localparam logic [2:0] IDX_LAST   = 3'd4;

  // Active-low segments, bit0 = a ... bit6 = g
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == IDX_LAST) ? IDX_TOTAL : idx + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_stat_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | perf_stat_sequencer_if                                                     |
// | Counter-bank inputs, halt/button controls and seven-segment display pins.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface perf_stat_sequencer_if;
  logic        halt;
  logic        btn_next;
  logic [31:0] total;
  logic [31:0] cond;
  logic [31:0] uncond;
  logic [31:0] cond_succ;
  logic [31:0] lu_times;
  logic [2:0]  disp_idx;
  logic [31:0] disp_val;
  logic        frozen;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  modport master (
    output halt, btn_next, total, cond, uncond, cond_succ, lu_times,
    input  disp_idx, disp_val, frozen, an_n, seg_n, dp_n
  );

  modport slave (
    input  halt, btn_next, total, cond, uncond, cond_succ, lu_times,
    output disp_idx, disp_val, frozen, an_n, seg_n, dp_n
  );
endinterface
`default_nettype wire

// File: rtl/perf_stat_sequencer_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan                                                                  |
// | Eight-digit multiplexed hex display driver with registered pin outputs.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_scan
  import perf_stat_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_disp_val,
  input  logic        i_frozen,
  output logic [7:0]  o_an_n,
  output logic [6:0]  o_seg_n,
  output logic        o_dp_n
);

  localparam int unsigned         C_PRE_W    = $clog2(SCAN_DIV);
  localparam logic [C_PRE_W-1:0]  c_pre_last = C_PRE_W'(SCAN_DIV - 1);

  logic [C_PRE_W-1:0] r_pre;
  logic [2:0]         r_digit;
  logic [2:0]         w_digit_nxt;
  logic               w_wrap;

  assign w_wrap      = (r_pre == c_pre_last);
  assign w_digit_nxt = w_wrap ? r_digit + 3'd1 : r_digit;

  // Pins are driven from the next digit so enable and glyph switch on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_digit <= 3'd0;
      o_an_n  <= 8'hFE;
      o_seg_n <= hex7(4'h0);
      o_dp_n  <= 1'b1;
    end else begin
      r_pre   <= w_wrap ? '0 : r_pre + 1'b1;
      r_digit <= w_digit_nxt;
      o_an_n  <= ~(8'd1 << w_digit_nxt);
      o_seg_n <= hex7(i_disp_val[{w_digit_nxt, 2'b00} +: 4]);
      o_dp_n  <= ~((w_digit_nxt == 3'd7) && i_frozen);
    end
  end

endmodule
`default_nettype wire

// File: rtl/perf_stat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | perf_stat_sequencer                                                        |
// | Picks one of five performance counters for the hex display, freezes them  |
// | on CPU halt and steps the selection on a debounced button.                 |
// | Optional: `define AUTO_ROTATE_EN for timed auto-advance in LIVE.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module perf_stat_sequencer
  import perf_stat_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned ROT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  perf_stat_sequencer_if.slave  bus
);

  localparam int unsigned        C_DEB_W    = $clog2(DEB_CYCLES);
  localparam logic [C_DEB_W-1:0] c_deb_last = C_DEB_W'(DEB_CYCLES - 1);

  if (SCAN_DIV < 2 || DEB_CYCLES < 2 || ROT_CYCLES < 2) begin : g_param_check
    $error("perf_stat_sequencer: SCAN_DIV, DEB_CYCLES and ROT_CYCLES must be >= 2");
  end

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_halt_q;
  logic [31:0]  r_shadow [5];
  logic [31:0]  w_live_sel;
  logic [31:0]  w_shadow_sel;
  logic [2:0]   r_idx;
  logic [31:0]  r_disp_val;
  logic         r_frozen;

  logic [1:0]         r_btn_sync;
  logic               r_btn_stable;
  logic [C_DEB_W-1:0] r_deb_cnt;
  logic               w_btn_differs;
  logic               w_deb_done;
  logic               w_btn_adv;
  logic               w_rot_tick;

  // ---------------- halt FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LIVE;
      r_halt_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halt_q <= bus.halt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LIVE:    if (bus.halt && !r_halt_q) w_state_nxt = SNAP;
      SNAP:    w_state_nxt = HOLD;
      HOLD:    if (!bus.halt) w_state_nxt = LIVE;
      default: w_state_nxt = LIVE;
    endcase
  end

  // ---------------- button debounce ----------------
  assign w_btn_differs = (r_btn_sync[1] != r_btn_stable);
  assign w_deb_done    = w_btn_differs && (r_deb_cnt == c_deb_last);
  assign w_btn_adv     = w_deb_done && r_btn_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_sync   <= 2'b00;
      r_btn_stable <= 1'b0;
      r_deb_cnt    <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], bus.btn_next};
      if (!w_btn_differs) begin
        r_deb_cnt <= '0;
      end else if (w_deb_done) begin
        r_btn_stable <= r_btn_sync[1];
        r_deb_cnt    <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // ---------------- optional auto-rotation ----------------
`ifdef AUTO_ROTATE_EN
  localparam int unsigned        C_ROT_W    = $clog2(ROT_CYCLES);
  localparam logic [C_ROT_W-1:0] c_rot_last = C_ROT_W'(ROT_CYCLES - 1);

  logic [C_ROT_W-1:0] r_rot_cnt;

  assign w_rot_tick = (r_state == LIVE) && (r_rot_cnt == c_rot_last);

  // A manual advance restarts the rotation interval
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rot_cnt <= '0;
    end else if ((r_state != LIVE) || w_btn_adv || w_rot_tick) begin
      r_rot_cnt <= '0;
    end else begin
      r_rot_cnt <= r_rot_cnt + 1'b1;
    end
  end
`else
  assign w_rot_tick = 1'b0;
`endif

  // ---------------- counter selection ----------------
  always_comb begin
    w_live_sel   = bus.total;
    w_shadow_sel = r_shadow[0];
    case (r_idx)
      IDX_COND:   begin w_live_sel = bus.cond;      w_shadow_sel = r_shadow[1]; end
      IDX_UNCOND: begin w_live_sel = bus.uncond;    w_shadow_sel = r_shadow[2]; end
      IDX_SUCC:   begin w_live_sel = bus.cond_succ; w_shadow_sel = r_shadow[3]; end
      IDX_LU:     begin w_live_sel = bus.lu_times;  w_shadow_sel = r_shadow[4]; end
      default:    begin w_live_sel = bus.total;     w_shadow_sel = r_shadow[0]; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= IDX_TOTAL;
      r_disp_val <= 32'd0;
      r_frozen   <= 1'b0;
      for (int i = 0; i < 5; i++) r_shadow[i] <= 32'd0;
    end else begin
      r_disp_val <= (r_state == HOLD) ? w_shadow_sel : w_live_sel;
      r_frozen   <= (r_state == HOLD);
      if (w_btn_adv || w_rot_tick) r_idx <= next_idx(r_idx);
      if (r_state == SNAP) begin
        r_shadow[0] <= bus.total;
        r_shadow[1] <= bus.cond;
        r_shadow[2] <= bus.uncond;
        r_shadow[3] <= bus.cond_succ;
        r_shadow[4] <= bus.lu_times;
      end
    end
  end

  assign bus.disp_idx = r_idx;
  assign bus.disp_val = r_disp_val;
  assign bus.frozen   = r_frozen;

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .i_disp_val (r_disp_val),
    .i_frozen   (r_frozen),
    .o_an_n     (bus.an_n),
    .o_seg_n    (bus.seg_n),
    .o_dp_n     (bus.dp_n)
  );

endmodule
`default_nettype wire

// File: tb/tb_perf_stat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_perf_stat_sequencer                                                     |
// | Self-checking bench: per-cycle reference model plus directed scenarios.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_perf_stat_sequencer;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int ROT_CYCLES = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  perf_stat_sequencer_if bus ();

  perf_stat_sequencer #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CYCLES (DEB_CYCLES),
    .ROT_CYCLES (ROT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Seven-segment glyphs, active-high gfedcba, inverted for the board
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] lit [16];
    lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return ~lit[d];
  endfunction

  // ---------------- reference model ----------------
  int          m_phase;      // 0 live, 1 snapshot cycle, 2 hold
  logic        m_halt_prev;
  logic [31:0] m_shadow [5];
  logic [31:0] m_live   [5];
  int          m_idx;
  logic [31:0] m_val;
  logic        m_frozen;
  logic        m_s0, m_s1, m_stable;
  int          m_run;
  int          m_rot;
  int          m_edges;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  int          m_digit;
  logic        m_accept, m_tick;

  task automatic model_reset();
    m_phase = 0; m_halt_prev = 1'b0; m_idx = 0; m_val = '0; m_frozen = 1'b0;
    for (int i = 0; i < 5; i++) m_shadow[i] = '0;
    m_s0 = 1'b0; m_s1 = 1'b0; m_stable = 1'b0; m_run = 0; m_rot = 0; m_edges = 0;
    m_an = 8'hFE; m_seg = glyph(4'h0); m_dp = 1'b1;
  endtask

  // Advance one clock edge, using the inputs that edge sampled
  task automatic model_step();
    m_live[0] = bus.total; m_live[1] = bus.cond; m_live[2] = bus.uncond;
    m_live[3] = bus.cond_succ; m_live[4] = bus.lu_times;
    m_edges++;
    m_digit = (m_edges / SCAN_DIV) % 8;
    m_an    = ~(8'd1 << m_digit);
    m_seg   = glyph(m_val[4*m_digit +: 4]);
    m_dp    = !(m_digit == 7 && m_frozen);
    // stable level flips after DEB_CYCLES consecutive differing synchronised samples
    m_accept = 1'b0;
    if (m_s1 != m_stable) begin
      m_run++;
      if (m_run == DEB_CYCLES) begin
        m_stable = m_s1; m_run = 0; m_accept = m_s1;
      end
    end else m_run = 0;
    m_s1 = m_s0; m_s0 = bus.btn_next;
`ifdef AUTO_ROTATE_EN
    m_tick = (m_phase == 0) && (m_rot == ROT_CYCLES - 1);
    if (m_phase != 0 || m_accept || m_tick) m_rot = 0; else m_rot++;
`else
    m_tick = 1'b0;
`endif
    m_val    = (m_phase == 2) ? m_shadow[m_idx] : m_live[m_idx];
    m_frozen = (m_phase == 2);
    if (m_phase == 1) for (int i = 0; i < 5; i++) m_shadow[i] = m_live[i];
    if (m_accept || m_tick) m_idx = (m_idx + 1) % 5;
    case (m_phase)
      0: if (bus.halt && !m_halt_prev) m_phase = 1;
      1: m_phase = 2;
      default: if (!bus.halt) m_phase = 0;
    endcase
    m_halt_prev = bus.halt;
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) model_reset(); else model_step();
      check("disp_idx", {29'd0, bus.disp_idx}, m_idx);
      check("disp_val", bus.disp_val, m_val);
      check("frozen",   {31'd0, bus.frozen}, {31'd0, m_frozen});
      check("an_n",     {24'd0, bus.an_n},   {24'd0, m_an});
      check("seg_n",    {25'd0, bus.seg_n},  {25'd0, m_seg});
      check("dp_n",     {31'd0, bus.dp_n},   {31'd0, m_dp});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    bus.btn_next = 1'b1;
    cyc(hold);
    bus.btn_next = 1'b0;
    cyc(8);
  endtask

  initial begin : stim
    logic found;
    bus.halt = 1'b0; bus.btn_next = 1'b0;
    bus.total = 32'h1234_5678; bus.cond = 32'd0; bus.uncond = 32'd0;
    bus.cond_succ = 32'd0; bus.lu_times = 32'd0;

    // 1: reset values and first scan digits
    cyc(2);
    check("rst_idx",  {29'd0, bus.disp_idx}, 32'd0);
    check("rst_val",  bus.disp_val, 32'd0);
    check("rst_an",   {24'd0, bus.an_n}, 32'hFE);
    check("rst_seg",  {25'd0, bus.seg_n}, 32'h40);
    rst = 1'b0;
    cyc(1);
    check("val_after_release", bus.disp_val, 32'h1234_5678);
    cyc(1);
    check("digit0_an",  {24'd0, bus.an_n}, 32'hFE);
    check("digit0_seg", {25'd0, bus.seg_n}, 32'h00);
    cyc(1);
    check("digit0_held", {24'd0, bus.an_n}, 32'hFE);
    cyc(1);
    check("digit1_an",  {24'd0, bus.an_n}, 32'hFD);
    check("digit1_seg", {25'd0, bus.seg_n}, 32'h78);

`ifndef AUTO_ROTATE_EN
    // 2: five presses wrap the index, a short glitch is ignored
    press(6); check("press1", {29'd0, bus.disp_idx}, 32'd1);
    press(6); check("press2", {29'd0, bus.disp_idx}, 32'd2);
    press(6); check("press3", {29'd0, bus.disp_idx}, 32'd3);
    press(6); check("press4", {29'd0, bus.disp_idx}, 32'd4);
    press(6); check("press5_wrap", {29'd0, bus.disp_idx}, 32'd0);
    press(2); check("glitch", {29'd0, bus.disp_idx}, 32'd0);

    // 3: snapshot of cond while the live counter moves on
    press(6);
    bus.cond = 32'd7;
    cyc(2);
    bus.halt = 1'b1;
    cyc(2);
    check("frozen_snap", {31'd0, bus.frozen}, 32'd0);
    bus.cond = 32'd9;
    cyc(1);
    check("frozen_hold", {31'd0, bus.frozen}, 32'd1);
    check("val_hold",    bus.disp_val, 32'd7);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (bus.an_n == 8'h7F) begin
        found = 1'b1;
        check("dp_digit7", {31'd0, bus.dp_n}, 32'd0);
      end
    end
    check("digit7_seen", {31'd0, found}, 32'd1);
    bus.halt = 1'b0;
    cyc(1);
    check("frozen_lag", {31'd0, bus.frozen}, 32'd1);
    cyc(1);
    check("unfrozen", {31'd0, bus.frozen}, 32'd0);
    check("val_live", bus.disp_val, 32'd9);

    // 4: presses while halted show shadow copies
    bus.total = 32'h0000_1000; bus.cond = 32'h22; bus.uncond = 32'h33;
    bus.cond_succ = 32'h44; bus.lu_times = 32'h55;
    bus.halt = 1'b1;
    cyc(3);
    bus.total = 32'hFFFF_0000; bus.cond = 32'hAAAA_0001; bus.uncond = 32'hBBBB_0002;
    bus.cond_succ = 32'hCCCC_0003; bus.lu_times = 32'hDDDD_0004;
    cyc(1);
    check("shadow_cond", bus.disp_val, 32'h22);
    press(6); check("shadow_uncond", bus.disp_val, 32'h33);
    press(6); check("shadow_succ",   bus.disp_val, 32'h44);
    press(6); check("shadow_lu",     bus.disp_val, 32'h55);
    check("hold_idx", {29'd0, bus.disp_idx}, 32'd4);
    bus.halt = 1'b0;
    cyc(3);
`endif

    // 6: async reset mid-debounce while holding
    bus.total = 32'h0BAD_F00D;
    bus.halt = 1'b1;
    cyc(4);
    bus.btn_next = 1'b1;
    cyc(3);
    rst = 1'b1;
    #1;
    check("arst_idx",    {29'd0, bus.disp_idx}, 32'd0);
    check("arst_val",    bus.disp_val, 32'd0);
    check("arst_frozen", {31'd0, bus.frozen}, 32'd0);
    check("arst_an",     {24'd0, bus.an_n}, 32'hFE);
    check("arst_seg",    {25'd0, bus.seg_n}, 32'h40);
    check("arst_dp",     {31'd0, bus.dp_n}, 32'd1);
    bus.halt = 1'b0; bus.btn_next = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("post_rst_val",    bus.disp_val, 32'h0BAD_F00D);
    check("post_rst_frozen", {31'd0, bus.frozen}, 32'd0);

    // 5: auto-rotation (or its absence)
`ifdef AUTO_ROTATE_EN
    cyc(17); check("rot_19",  {29'd0, bus.disp_idx}, 32'd0);
    cyc(1);  check("rot_20",  {29'd0, bus.disp_idx}, 32'd1);
    cyc(20); check("rot_40",  {29'd0, bus.disp_idx}, 32'd2);
    cyc(20); check("rot_60",  {29'd0, bus.disp_idx}, 32'd3);
    cyc(20); check("rot_80",  {29'd0, bus.disp_idx}, 32'd4);
    cyc(20); check("rot_100", {29'd0, bus.disp_idx}, 32'd0);
    cyc(15);
    bus.btn_next = 1'b1;
    cyc(5);  check("rot_btn_same_cycle", {29'd0, bus.disp_idx}, 32'd1);
    bus.btn_next = 1'b0;
    cyc(8);
`else
    cyc(98);
    check("no_rotate", {29'd0, bus.disp_idx}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
